// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared types and constants for the multicycle controller
//
// Purpose: state enumeration, opcode/funct encodings, ALU operation codes and
//          mux-select encodings shared by the controller, its decoder and the bus.
// Ports:   none (package).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXECUTE,
    R_WB,
    BRANCH,
    JUMP,
    ADDI_EXEC,
    ADDI_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction-field inputs and control outputs of the controller
//
// Purpose: bundles the instruction fields / ALU flag fed to the controller and
//          the datapath control word it produces.
// Ports:   opcode[5:0], funct[5:0], zero           (datapath -> controller)
//          alu_operation[2:0], alu_src_b[1:0], pc_src[1:0], pc_write, iord,
//          mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
//          alu_src_a                                (controller -> datapath)
// Modports: master = datapath side, slave = controller side.
interface multicycle_controller_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic [2:0] alu_operation;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;

  modport master (
    output opcode, funct, zero,
    input  alu_operation, pc_write, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src
  );

  modport slave (
    input  opcode, funct, zero,
    output alu_operation, pc_write, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src
  );

endinterface

// File: rtl/multicycle_controller_alu_op_decoder.sv
// rtl/multicycle_controller_alu_op_decoder.sv - R-type funct field to ALU operation decoder
//
// Purpose: purely combinational map of funct to an ALU operation code.
// Ports:   funct[5:0] in; alu_operation[2:0] out; valid out (funct recognised).
//          Unrecognised funct yields ALU_ADD with valid=0.
module alu_op_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_operation,
  output logic       valid
);

  always_comb begin
    alu_operation = ALU_ADD;
    valid         = 1'b1;
    case (funct)
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_AND:  alu_operation = ALU_AND;
      FN_OR:   alu_operation = ALU_OR;
      FN_SLT:  alu_operation = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM control unit for a multicycle MIPS-style datapath
//
// Purpose: sequences FETCH/DECODE and the per-instruction states, producing the
//          datapath control word for each state.
// Ports:   clk   - rising-edge clock
//          rst_n - asynchronous active-low reset (forces FETCH, outputs to 0)
//          bus   - multicycle_controller_if.slave (opcode/funct/zero in, controls out)
module multicycle_controller
  import mc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  multicycle_controller_if.slave       bus
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] funct_op;
  logic       funct_valid;

  alu_op_decoder u_alu_op_decoder (
    .funct         (bus.funct),
    .alu_operation (funct_op),
    .valid         (funct_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_ADDI:      state_nxt = ADDI_EXEC;
          default:      state_nxt = FETCH;
        endcase
      end
      // The instruction register holds the opcode steady, so lw/sw is
      // resolved here without a dedicated flop.
      MEM_ADDR:  state_nxt = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_nxt = MEM_WB;
      // An unrecognised funct abandons the instruction before writeback.
      EXECUTE:   state_nxt = funct_valid ? R_WB : FETCH;
      ADDI_EXEC: state_nxt = ADDI_WB;
      default:   state_nxt = FETCH;
    endcase
  end

  // Outputs are gated by rst_n so they drop the instant reset asserts,
  // independent of the clock.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.pc_src        = PCSRC_ALU;
    bus.alu_operation = ALU_ADD;
    if (rst_n) begin
      case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.ir_write  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_write  = 1'b1;
        end
        DECODE: bus.alu_src_b = SRCB_IMM_SH;
        MEM_ADDR, ADDI_EXEC: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = SRCB_IMM;
        end
        MEM_READ: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        MEM_WRITE: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        EXECUTE: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_operation = funct_op;
        end
        R_WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        ADDI_WB: bus.reg_write = 1'b1;
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_operation = ALU_SUB;
          bus.pc_src        = PCSRC_ALUOUT;
          bus.pc_write      = bus.zero;
        end
        JUMP: begin
          bus.pc_src   = PCSRC_JUMP;
          bus.pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control word: {pc_write, iord, mem_read, mem_write, ir_write, mem_to_reg,
  //                reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_operation}
  function automatic logic [15:0] dut_word();
    return {bus.pc_write, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.pc_src, bus.alu_operation};
  endfunction

  function automatic logic [15:0] mk(input bit pcw, input bit iord, input bit mr, input bit mw,
                                     input bit irw, input bit m2r, input bit rd, input bit rw,
                                     input bit asa, input bit [1:0] asb, input bit [1:0] psrc,
                                     input bit [2:0] aop);
    return {pcw, iord, mr, mw, irw, m2r, rd, rw, asa, asb, psrc, aop};
  endfunction

  function automatic bit ref_funct(input logic [5:0] fn, output logic [2:0] aop);
    case (fn)
      6'b100000: begin aop = 3'b000; return 1'b1; end
      6'b100010: begin aop = 3'b001; return 1'b1; end
      6'b100100: begin aop = 3'b010; return 1'b1; end
      6'b100101: begin aop = 3'b011; return 1'b1; end
      6'b101010: begin aop = 3'b101; return 1'b1; end
      default:   begin aop = 3'b000; return 1'b0; end
    endcase
  endfunction

  // Reference model: the per-cycle control words an instruction should produce.
  task automatic build_expected(input logic [5:0] op, input logic [5:0] fn, input bit z);
    logic [2:0] aop;
    exp_q = {};
    exp_q.push_back(mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b000));
    exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000));
    case (op)
      6'b000000: begin
        if (ref_funct(fn, aop)) begin
          exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,aop));
          exp_q.push_back(mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000));
        end else begin
          exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000));
        end
      end
      6'b100011: begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000));
        exp_q.push_back(mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000));
        exp_q.push_back(mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000));
      end
      6'b101011: begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000));
        exp_q.push_back(mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000));
      end
      6'b000100: exp_q.push_back(mk(z,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b001));
      6'b000010: exp_q.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000));
      6'b001000: begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000));
        exp_q.push_back(mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000));
      end
      default: ;
    endcase
  endtask

  // Called just after a rising edge with the DUT in FETCH. Checks every cycle
  // of the instruction; abort_at >= 0 pulls reset during that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int abort_at);
    build_expected(op, fn, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == 0) begin
        // Fields present during FETCH must not influence anything.
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
        bus.zero   = 1'($urandom);
      end else begin
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
      end
      @(negedge clk);
      check($sformatf("op%b_fn%b_z%0d_c%0d", op, fn, z, i), dut_word(), exp_q[i]);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", dut_word(), 16'h0000);
        @(posedge clk);
        #1 check("reset_hold_outputs", dut_word(), 16'h0000);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] op_tab[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    rst_n      = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct  = 6'b100000;
    bus.zero   = 1'b0;
    #3 check("reset_outputs", dut_word(), 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1 check("reset_outputs_clocked", dut_word(), 16'h0000);
    rst_n = 1'b1;

    run_instr(6'b000000, 6'b100000, 1'b0, -1);   // R add
    run_instr(6'b100011, 6'b000000, 1'b0, -1);   // lw
    run_instr(6'b000100, 6'b000000, 1'b1, -1);   // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, -1);   // beq not taken
    run_instr(6'b000000, 6'b101010, 1'b0, -1);   // slt
    run_instr(6'b000000, 6'b111111, 1'b0, -1);   // unknown funct
    run_instr(6'b100011, 6'b000000, 1'b0, 3);    // lw reset during MEM_READ
    run_instr(6'b111111, 6'b000000, 1'b0, -1);   // unknown opcode
    run_instr(6'b101011, 6'b000000, 1'b0, -1);   // sw
    run_instr(6'b001000, 6'b000000, 1'b0, -1);   // addi
    run_instr(6'b000010, 6'b000000, 1'b1, -1);   // j

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 6) rop = 6'($urandom);
      else                           rop = op_tab[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) rfn = 6'($urandom);
      else                           rfn = fn_tab[$urandom_range(0, 4)];
      run_instr(rop, rfn, 1'($urandom), ($urandom_range(0, 9) == 0) ? 1 : -1);
    end

    // The instruction stream must end back in FETCH.
    bus.opcode = 6'b000000;
    @(negedge clk);
    check("final_fetch", dut_word(), mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
